// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared types and default sizes for the scoreboarded register file
package regfile_sb_pkg;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write, read, reserve and control signals of the register file
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NRD        = 2
);
    logic                                we;
    logic [ADDR_WIDTH-1:0]               waddr;
    logic [WIDTH-1:0]                    wdata;
    logic [NRD-1:0][ADDR_WIDTH-1:0]      raddr;
    logic [NRD-1:0][WIDTH-1:0]           rdata;
    logic [NRD-1:0]                      rbusy;
    logic                                rsv_valid;
    logic [ADDR_WIDTH-1:0]               rsv_addr;
    logic                                clear_req;
    logic                                ready;

    modport master (
        output we, waddr, wdata, raddr, rsv_valid, rsv_addr, clear_req,
        input  rdata, rbusy, ready
    );

    modport slave (
        input  we, waddr, wdata, raddr, rsv_valid, rsv_addr, clear_req,
        output rdata, rbusy, ready
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits; reserve beats write-clear, bulk clear beats both
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_all,
    input  logic                       set_en,
    input  logic [ADDR_WIDTH-1:0]      set_addr,
    input  logic                       clr_en,
    input  logic [ADDR_WIDTH-1:0]      clr_addr,
    output logic [2**ADDR_WIDTH-1:0]   busy
);
    logic [2**ADDR_WIDTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (set_en)
            busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else if (clr_all)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with init sweep, write bypass and busy scoreboard
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NRD        = 2,
    parameter int BYPASS     = 1
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);
    localparam int NREGS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NREGS - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    ready_q;
    logic                    run;
    logic                    wr_en;
    logic                    rsv_en;
    logic [WIDTH-1:0]        mem [NREGS];
    logic [NREGS-1:0]        busy;

    assign run    = (state == RUN);
    assign wr_en  = run && bus.we && (bus.waddr != '0);
    assign rsv_en = run && bus.rsv_valid && (bus.rsv_addr != '0);
    assign bus.ready = ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INIT;
            cnt     <= ADDR_WIDTH'(1);
            ready_q <= 1'b0;
        end else if (bus.clear_req) begin
            state   <= INIT;
            cnt     <= ADDR_WIDTH'(1);
            ready_q <= 1'b0;
        end else if (state == INIT) begin
            if (cnt == LAST) begin
                state   <= RUN;
                ready_q <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Entry 0 is never stored to; reads of it are forced to zero instead.
    always_ff @(posedge clk) begin
        if (!run)
            mem[cnt] <= '0;
        else if (wr_en)
            mem[bus.waddr] <= bus.wdata;
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (bus.clear_req),
        .set_en   (rsv_en),
        .set_addr (bus.rsv_addr),
        .clr_en   (wr_en),
        .clr_addr (bus.waddr),
        .busy     (busy)
    );

    always_comb begin
        logic hit;
        logic rsv_hit;
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            hit     = (BYPASS != 0) && wr_en && (bus.waddr == bus.raddr[i]);
            rsv_hit = rsv_en && (bus.rsv_addr == bus.raddr[i]);
            if (run && (bus.raddr[i] != '0)) begin
                bus.rdata[i] = hit ? bus.wdata : mem[bus.raddr[i]];
                bus.rbusy[i] = busy[bus.raddr[i]] && !(hit && !rsv_hit);
            end
        end
    end
endmodule
